arbiter_rr_nway: RTL and testbench
==================================

ARBITER_RR_NWAY -- requirements
Module: arbiter_rr_nway

Interface
REQ-001 Parameter N, default 4: number of client channels, legal range 2..16.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops on every asynchronous input, legal range 2..3.
REQ-003 Parameter USE_PARENT, default 1: 1 = parent handshake via rc_o/gc_i active; 0 = gc_i ignored, stand-alone root arbiter.
REQ-004 Power pins vccd1/vssd1 SHALL be present only under USE_POWER_PINS.
REQ-005 wb_clk_i  input  1  single clock; all state on rising edge.
REQ-006 wb_rst_i  input  1  reset, asynchronous assertion, active-high.
REQ-007 req_i  input  N  per-channel 4-phase request, asynchronous to wb_clk_i.
REQ-008 gnt_o  output  N  per-channel grant, registered, at most one bit set.
REQ-009 rc_o  output  1  request to parent arbiter, registered.
REQ-010 gc_i  input  1  grant from parent, asynchronous to wb_clk_i.
REQ-011 gnt_id_o  output  $clog2(N)  index of current/last winner, registered.
REQ-012 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-013 req_i and gc_i SHALL each pass through SYNC_STAGES flops before use (req_s, gc_s); no other logic on raw inputs.
REQ-014 FSM states: IDLE, WAIT_G, GRANT, WAIT_R; one-hot or binary is implementer's choice.
REQ-015 IDLE: if any req_s bit high -> rc_o<=1, go WAIT_G (USE_PARENT=1); with USE_PARENT=0 select winner immediately per REQ-017 and go GRANT.
REQ-016 WAIT_G: on gc_s high select winner; if a winner exists gnt_o[w]<=1, gnt_id_o<=w, go GRANT; if all requests withdrew, rc_o<=0, go WAIT_R.
REQ-017 Winner = lowest index >= ptr with req_s set, wrapping modulo N; selection sampled in the single cycle of the transition.
REQ-018 GRANT: hold gnt_o stable; when req_s[w] low -> gnt_o<=0, rc_o<=0, ptr<=(w+1) mod N (N-1 wraps to 0), go WAIT_R (USE_PARENT=0: go IDLE).
REQ-019 WAIT_R: when gc_s low go IDLE; new requests wait until then.
REQ-020 Requests of non-winning channels arriving or dropping during GRANT SHALL NOT affect gnt_o.
REQ-021 Latency: req_i rise to rc_o rise = SYNC_STAGES+1 cycles from idle; gc_i rise to gnt_o rise = SYNC_STAGES+1 cycles; req_i[w] fall to gnt_o fall = SYNC_STAGES+1 cycles.
REQ-022 Fairness: with all N channels continuously cycling, each channel SHALL be granted exactly once per N grants.
REQ-023 gc_i high while in IDLE (parent protocol violation) SHALL be ignored.

Reset
REQ-024 wb_rst_i high SHALL immediately force state=IDLE, gnt_o=0, rc_o=0, gnt_id_o=0, ptr=0, busy_o=0, and clear all synchroniser flops.
REQ-025 Reset asserted mid-grant SHALL drop gnt_o and rc_o asynchronously; after release the block SHALL resume from IDLE with ptr=0.
REQ-026 Deassertion is synchronised externally; no internal reset synchroniser.

Structure
REQ-027 State encoding localparams and the modulo-N pointer-increment function SHALL live in shared package arbiter_pkg.
REQ-028 One sub-module sync_ff (parametrised width and depth, async active-high clear) SHALL implement REQ-013.
REQ-029 Priority selection SHALL be combinational, rotate-then-priority-encode, no loops longer than N.

Verification (N=4, SYNC_STAGES=2, USE_PARENT=1 unless stated)
REQ-030 req_i=0001, parent echoes gc_i=rc_o -> rc_o high 3 cycles after req, gnt_o=0001 3 cycles after gc_i, full 4-phase closes, ptr=1.
REQ-031 req_i=1111 held, each winner drops req after grant then re-raises -> grant order 0,1,2,3,0; gnt_id_o tracks.
REQ-032 ptr=3, req_i=0101 -> winner 0 (wrap), then ptr=1, next winner 2.
REQ-033 req_i=0010 raised then dropped before gc_i -> no gnt_o pulse, rc_o falls, returns IDLE after gc_i low.
REQ-034 wb_rst_i pulsed while gnt_o=0100 -> gnt_o=0, rc_o=0 same cycle without clock; next request won by index 0 priority.
REQ-035 USE_PARENT=0, gc_i tied 0, req_i=0011 -> gnt_o=0001 then 0010 with no rc_o dependency.

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared definitions for the round-robin N-way arbiter: FSM state encoding
// and the modulo-N pointer increment.
package arbiter_pkg;

  // Pointer arithmetic is done at a fixed width that covers N up to 16.
  localparam int unsigned PTR_W   = 4;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_G = 2'd1,
    ST_GRANT  = 2'd2,
    ST_WAIT_R = 2'd3
  } state_t;

  // Next pointer after winner p; index n-1 wraps back to 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p,
                                               input logic [PTR_W:0]   n);
    logic [PTR_W-1:0] r;
    if ({1'b0, p} >= n - (PTR_W + 1)'(1)) begin
      r = '0;
    end else begin
      r = p + PTR_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchroniser for asynchronous inputs, cleared asynchronously
// by an active-high clear.
module sync_ff #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift chain: stage 0 samples the raw input, the last stage is the output.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/arbiter_rr_nway.sv
// Round-robin arbiter for N asynchronous 4-phase clients, optionally chained
// to a parent arbiter through an rc_o/gc_i handshake.
module arbiter_rr_nway
  import arbiter_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned USE_PARENT  = 1
) (
`ifdef USE_POWER_PINS
  inout  wire                  vccd1,
  inout  wire                  vssd1,
`endif
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [N-1:0]         req_i,
  output logic [N-1:0]         gnt_o,
  output logic                 rc_o,
  input  logic                 gc_i,
  output logic [$clog2(N)-1:0] gnt_id_o,
  output logic                 busy_o
);

  localparam int unsigned IDW = $clog2(N);
  localparam int unsigned SW  = IDW + 1;

  logic [N-1:0]   req_s;
  logic           gc_s;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           rc_q, rc_d;
  logic           busy_q;

  logic [N-1:0]   req_rot;
  logic [IDW-1:0] offs;
  logic [SW-1:0]  sum;
  logic [IDW-1:0] win;
  logic           win_vld;

  sync_ff #(
    .WIDTH (N),
    .DEPTH (SYNC_STAGES)
  ) u_sync_req (
    .clk (wb_clk_i),
    .clr (wb_rst_i),
    .d   (req_i),
    .q   (req_s)
  );

  sync_ff #(
    .WIDTH (1),
    .DEPTH (SYNC_STAGES)
  ) u_sync_gc (
    .clk (wb_clk_i),
    .clr (wb_rst_i),
    .d   (gc_i),
    .q   (gc_s)
  );

  // Rotate requests so ptr lands on bit 0, take the lowest set bit, then
  // map the offset back to an absolute channel index.
  always_comb begin
    req_rot = N'({req_s, req_s} >> ptr_q);
    offs    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        offs = IDW'(i);
      end
    end
    sum = {1'b0, ptr_q} + {1'b0, offs};
    if (sum >= SW'(N)) begin
      sum = sum - SW'(N);
    end
    win     = sum[IDW-1:0];
    win_vld = |req_s;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    rc_d    = rc_q;

    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          if (USE_PARENT != 0) begin
            rc_d    = 1'b1;
            state_d = ST_WAIT_G;
          end else begin
            gnt_d   = N'(1) << win;
            id_d    = win;
            state_d = ST_GRANT;
          end
        end
      end

      ST_WAIT_G: begin
        // All clients withdrew: give the parent request back without granting.
        if (!win_vld) begin
          rc_d    = 1'b0;
          state_d = ST_WAIT_R;
        end else if (gc_s) begin
          gnt_d   = N'(1) << win;
          id_d    = win;
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        // Only the winner's request matters while the grant is held.
        if (!req_s[id_q]) begin
          gnt_d   = '0;
          rc_d    = 1'b0;
          ptr_d   = IDW'(ptr_inc(PTR_W'(id_q), (PTR_W + 1)'(N)));
          state_d = (USE_PARENT != 0) ? ST_WAIT_R : ST_IDLE;
        end
      end

      ST_WAIT_R: begin
        if (!gc_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      rc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      rc_q    <= rc_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign gnt_o    = gnt_q;
  assign gnt_id_o = id_q;
  assign rc_o     = rc_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_arbiter_rr_nway.sv
// Scoreboard bench for arbiter_rr_nway: a parented instance (gc echoed from
// rc or driven by hand) and a stand-alone root instance.
module tb_arbiter_rr_nway;

  localparam int N      = 4;
  localparam int IDW    = 2;
  localparam int BUDGET = 40;
  localparam int S_GNT  = 0;
  localparam int S_RC   = 1;
  localparam int S_BUSY = 2;
  localparam int S_GNT2 = 3;

  typedef struct packed {
    logic [N-1:0]   gnt;
    logic [IDW-1:0] id;
  } exp_t;

`ifdef USE_POWER_PINS
  wire vccd1 = 1'b1;
  wire vssd1 = 1'b0;
`endif

  logic           wb_clk;
  logic           wb_rst;
  logic [N-1:0]   req, req2;
  logic           gc_man, echo_en;
  logic           gc, gc2;
  logic [N-1:0]   gnt, gnt2;
  logic           rc, rc2;
  logic [IDW-1:0] gid, gid2;
  logic           busy, busy2;

  int             checks   = 0;
  int             failures = 0;
  int             mptr     = 0;
  exp_t           sb[$];
  exp_t           sb2[$];
  exp_t           e1, e2;
  logic [N-1:0]   prev_g  = '0;
  logic [N-1:0]   prev_g2 = '0;

  assign gc  = echo_en ? rc : gc_man;
  assign gc2 = 1'b0;

  arbiter_rr_nway #(.N(N), .SYNC_STAGES(2), .USE_PARENT(1)) dut (
`ifdef USE_POWER_PINS
    .vccd1    (vccd1),
    .vssd1    (vssd1),
`endif
    .wb_clk_i (wb_clk),
    .wb_rst_i (wb_rst),
    .req_i    (req),
    .gnt_o    (gnt),
    .rc_o     (rc),
    .gc_i     (gc),
    .gnt_id_o (gid),
    .busy_o   (busy)
  );

  arbiter_rr_nway #(.N(N), .SYNC_STAGES(2), .USE_PARENT(0)) dut_np (
`ifdef USE_POWER_PINS
    .vccd1    (vccd1),
    .vssd1    (vssd1),
`endif
    .wb_clk_i (wb_clk),
    .wb_rst_i (wb_rst),
    .req_i    (req2),
    .gnt_o    (gnt2),
    .rc_o     (rc2),
    .gc_i     (gc2),
    .gnt_id_o (gid2),
    .busy_o   (busy2)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Reference winner: first requesting channel walking up from p, modulo N.
  function automatic int model_win(input logic [N-1:0] r, input int p);
    int idx;
    model_win = -1;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (p + k) % N;
      if (r[idx]) model_win = idx;
    end
  endfunction

  task automatic expect_win(input logic [N-1:0] pat, output int w);
    exp_t e;
    w     = model_win(pat, mptr);
    e.gnt = N'(1) << w;
    e.id  = IDW'(w);
    sb.push_back(e);
    mptr  = (w + 1) % N;
  endtask

  task automatic wait_for(input int sel, input logic want, input string tag, output int cyc);
    logic v;
    cyc = 0;
    v   = ~want;
    while (v != want && cyc < BUDGET) begin
      @(negedge wb_clk);
      cyc++;
      case (sel)
        S_GNT:   v = |gnt;
        S_RC:    v = rc;
        S_BUSY:  v = busy;
        default: v = |gnt2;
      endcase
    end
    check({tag, "_seen"}, 32'(v), 32'(want));
  endtask

  // One full arbitration; non-winning requests drop and re-arrive mid-grant.
  task automatic arb_one(input logic [N-1:0] pat, input string tag);
    int           w, cyc;
    logic [N-1:0] g;
    expect_win(pat, w);
    g   = N'(1) << w;
    req = pat;
    wait_for(S_GNT, 1'b1, tag, cyc);
    req = pat & g;
    repeat (4) @(negedge wb_clk);
    req = pat;
    repeat (4) @(negedge wb_clk);
    check({tag, "_hold"}, 32'(gnt), 32'(g));
    req = '0;
    wait_for(S_GNT, 1'b0, {tag, "_rel"}, cyc);
    wait_for(S_BUSY, 1'b0, {tag, "_idle"}, cyc);
  endtask

  // Scoreboard pop on every new grant of each instance.
  always @(negedge wb_clk) begin
    if (gnt != '0 && gnt != prev_g) begin
      if (sb.size() == 0) begin
        check("unexpected_gnt", 32'(gnt), 32'(0));
      end else begin
        e1 = sb.pop_front();
        check("sb_gnt", 32'(gnt), 32'(e1.gnt));
        check("sb_id", 32'(gid), 32'(e1.id));
      end
    end
    prev_g = gnt;
  end

  always @(negedge wb_clk) begin
    if (gnt2 != '0 && gnt2 != prev_g2) begin
      if (sb2.size() == 0) begin
        check("np_unexpected_gnt", 32'(gnt2), 32'(0));
      end else begin
        e2 = sb2.pop_front();
        check("np_sb_gnt", 32'(gnt2), 32'(e2.gnt));
        check("np_sb_id", 32'(gid2), 32'(e2.id));
      end
    end
    prev_g2 = gnt2;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc, w;
    exp_t e;
    wb_rst  = 1'b1;
    req     = '0;
    req2    = '0;
    gc_man  = 1'b0;
    echo_en = 1'b1;
    repeat (3) @(negedge wb_clk);
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_rc", 32'(rc), 32'(0));
    check("rst_id", 32'(gid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    wb_rst = 1'b0;
    repeat (2) @(negedge wb_clk);

    // Single client, full 4-phase with echoing parent.
    expect_win(4'b0001, w);
    req = 4'b0001;
    wait_for(S_RC, 1'b1, "p1_rc", cyc);
    check("p1_rc_lat", cyc, 3);
    wait_for(S_GNT, 1'b1, "p1_gnt", cyc);
    check("p1_gnt_lat", cyc, 3);
    check("p1_busy", 32'(busy), 32'(1));
    req = '0;
    wait_for(S_GNT, 1'b0, "p1_rel", cyc);
    check("p1_rel_lat", cyc, 3);
    check("p1_rc_drop", 32'(rc), 32'(0));
    wait_for(S_BUSY, 1'b0, "p1_idle", cyc);

    // ptr=1 -> 2, ptr=3 -> 0 (wrap), ptr=1 -> 2.
    arb_one(4'b0101, "ptr1");
    arb_one(4'b0101, "wrap");
    arb_one(4'b0101, "after_wrap");

    // Request withdrawn before the parent grants.
    echo_en = 1'b0;
    gc_man  = 1'b0;
    req     = 4'b0010;
    wait_for(S_RC, 1'b1, "wd_rc", cyc);
    req = '0;
    repeat (4) @(negedge wb_clk);
    gc_man = 1'b1;
    wait_for(S_RC, 1'b0, "wd_rc_fall", cyc);
    repeat (3) @(negedge wb_clk);
    gc_man = 1'b0;
    wait_for(S_BUSY, 1'b0, "wd_idle", cyc);
    check("wd_gnt", 32'(gnt), 32'(0));

    // Parent grant while idle is ignored.
    repeat (3) @(negedge wb_clk);
    gc_man = 1'b1;
    repeat (6) @(negedge wb_clk);
    check("idle_gc_busy", 32'(busy), 32'(0));
    check("idle_gc_rc", 32'(rc), 32'(0));
    gc_man = 1'b0;
    repeat (4) @(negedge wb_clk);
    echo_en = 1'b1;

    // Fresh pointer, all four clients cycling: order 0,1,2,3,0.
    wb_rst = 1'b1;
    @(negedge wb_clk);
    wb_rst = 1'b0;
    mptr   = 0;
    repeat (2) @(negedge wb_clk);
    expect_win(4'b1111, w);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_for(S_GNT, 1'b1, "rr_gnt", cyc);
      req[w] = 1'b0;
      wait_for(S_GNT, 1'b0, "rr_rel", cyc);
      if (i < 4) begin
        req[w] = 1'b1;
        expect_win(4'b1111, w);
      end
    end
    req = '0;
    wait_for(S_BUSY, 1'b0, "rr_idle", cyc);

    // Asynchronous reset mid-grant, then index 0 has priority again.
    expect_win(4'b0100, w);
    req = 4'b0100;
    wait_for(S_GNT, 1'b1, "rm_gnt", cyc);
    check("rm_rc_pre", 32'(rc), 32'(1));
    #2 wb_rst = 1'b1;
    #1;
    check("rm_gnt0", 32'(gnt), 32'(0));
    check("rm_rc0", 32'(rc), 32'(0));
    check("rm_busy0", 32'(busy), 32'(0));
    check("rm_id0", 32'(gid), 32'(0));
    req = '0;
    @(negedge wb_clk);
    @(negedge wb_clk);
    wb_rst = 1'b0;
    mptr   = 0;
    repeat (2) @(negedge wb_clk);
    arb_one(4'b1001, "post_rst");

    // Stand-alone root: no parent handshake at all.
    e.gnt = 4'b0001; e.id = 2'd0; sb2.push_back(e);
    e.gnt = 4'b0010; e.id = 2'd1; sb2.push_back(e);
    req2 = 4'b0011;
    wait_for(S_GNT2, 1'b1, "np_gnt", cyc);
    check("np_gnt_lat", cyc, 3);
    check("np_rc", 32'(rc2), 32'(0));
    req2 = 4'b0010;
    wait_for(S_GNT2, 1'b0, "np_rel", cyc);
    wait_for(S_GNT2, 1'b1, "np_gnt_b", cyc);
    check("np_rc_b", 32'(rc2), 32'(0));
    req2 = '0;
    wait_for(S_GNT2, 1'b0, "np_rel_b", cyc);
    repeat (3) @(negedge wb_clk);

    check("sb_drain", 32'(sb.size()), 32'(0));
    check("np_sb_drain", 32'(sb2.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
